// File: rtl/swc_cell_pkg.sv
// Shared constants, status/pointer field positions and FSM states for the cell segmenter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package swc_cell_pkg;

   localparam int CELL_BYTES     = 64;
   localparam int BEAT_BYTES     = 16;
   localparam int BEATS_PER_CELL = 4;

   localparam int LEN_W = 11;
   localparam int CNT_W = 6;

   // Ingress status word layout
   localparam int STAT_ERR     = 15;
   localparam int STAT_PMAP_HI = 14;
   localparam int STAT_PMAP_LO = 11;
   localparam int STAT_LEN_HI  = 10;
   localparam int STAT_LEN_LO  = 0;

   // Cell pointer word layout
   localparam int PTR_PMAP_HI = 11;
   localparam int PTR_PMAP_LO = 8;
   localparam int PTR_CNT_HI  = 5;
   localparam int PTR_CNT_LO  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PACK,
      ST_PAD,
      ST_PTR,
      ST_DROP
   } seg_state_t;

   // Number of 64-byte cells needed to hold len bytes (rounded up).
   function automatic logic [CNT_W-1:0] cells_for_len(input logic [LEN_W-1:0] len);
      logic [LEN_W:0] sum;
      sum = {1'b0, len} + (LEN_W+1)'(CELL_BYTES - 1);
      return sum[LEN_W:$clog2(CELL_BYTES)];
   endfunction

endpackage

// File: rtl/cell_beat_packer.sv
// Packs a byte stream MSB-first into 128-bit beats; zero-fills the tail of a partial last beat.
// Latency: beat write registered, 1 cycle after the byte that completes (or ends) the beat.
// Backpressure: none; the caller only presents bytes when it can pop them.
// Ports: clk/rstn; clr restarts lane count; byte_vld/byte_dat/byte_last feed bytes;
//        pad_vld emits an all-zero beat; beat_done flags that this byte closes a beat;
//        beat_dat/beat_wr are the registered beat output.
module cell_beat_packer
   import swc_cell_pkg::*;
(
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         byte_vld,
   input  logic [7:0]   byte_dat,
   input  logic         byte_last,
   input  logic         pad_vld,
   output logic         beat_done,
   output logic [127:0] beat_dat,
   output logic         beat_wr
);

   localparam int LANE_W = $clog2(BEAT_BYTES);
   localparam int BEAT_W = BEAT_BYTES * 8;

   logic [LANE_W-1:0] lane;
   logic [BEAT_W-1:0] acc;
   logic [BEAT_W-1:0] acc_nxt;
   logic [BEAT_W-1:0] flush_dat;

   assign acc_nxt   = {acc[BEAT_W-9:0], byte_dat};
   assign beat_done = byte_vld && ((lane == LANE_W'(BEAT_BYTES - 1)) || byte_last);
   // Left-justify: shift the unused (15-lane) byte lanes out as zeros.
   assign flush_dat = acc_nxt << {~lane, 3'b000};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc      <= '0;
         lane     <= '0;
         beat_dat <= '0;
         beat_wr  <= 1'b0;
      end else begin
         beat_wr <= 1'b0;
         if (clr) begin
            acc  <= '0;
            lane <= '0;
         end else if (pad_vld) begin
            beat_dat <= '0;
            beat_wr  <= 1'b1;
         end else if (byte_vld) begin
            if (beat_done) begin
               beat_dat <= flush_dat;
               beat_wr  <= 1'b1;
               acc      <= '0;
               lane     <= '0;
            end else begin
               acc  <= acc_nxt;
               lane <= lane + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/frame_cell_segmenter.sv
// Pops whole frames from the ingress FIFOs, packs them into zero-padded 64B cells, writes one pointer per frame.
// Latency: stat pop 1 cycle after decision; beats 1 cycle after their 16th byte; pointer 1 cycle after PTR.
// Backpressure: i_cell_bp only holds off new good frames in IDLE; started frames and drops run to completion.
// Ports: status FIFO (dout/empty/rd), byte FIFO (dout/empty/rd), cell data FIFO (din/wr),
//        cell pointer FIFO (din/wr), i_cell_bp, forwarded/dropped frame counters.
module frame_cell_segmenter
   import swc_cell_pkg::*;
#(
   parameter int MAX_LEN = 1518,
   parameter int MIN_LEN = 1
)(
   input  logic         clk,
   input  logic         rstn,
   input  logic [15:0]  i_stat_fifo_dout,
   input  logic         i_stat_fifo_empty,
   output logic         i_stat_fifo_rd,
   input  logic [7:0]   i_data_fifo_dout,
   input  logic         i_data_fifo_empty,
   output logic         i_data_fifo_rd,
   output logic [127:0] o_cell_data_fifo_din,
   output logic         o_cell_data_fifo_wr,
   output logic [15:0]  o_cell_ptr_fifo_din,
   output logic         o_cell_ptr_fifo_wr,
   input  logic         i_cell_bp,
   output logic [15:0]  o_frame_cnt,
   output logic [15:0]  o_drop_cnt
);

   seg_state_t state, state_nxt;

   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] rem;
   logic [3:0]       pmap_q;
   logic [CNT_W-1:0] cell_cnt;
   logic [1:0]       beat_cnt;
   logic [1:0]       beat_cnt_inc;
   logic             stat_rd_q;
   logic             ptr_wr_q;
   logic [15:0]      ptr_dat_q;
   logic [15:0]      ptr_word;

   logic             st_err;
   logic [3:0]       st_pmap;
   logic [LEN_W-1:0] st_len;
   logic             st_bad;
   logic             stat_take;
   logic             pop;
   logic             pad_vld;
   logic             clr;
   logic             beat_done;

   assign st_err  = i_stat_fifo_dout[STAT_ERR];
   assign st_pmap = i_stat_fifo_dout[STAT_PMAP_HI:STAT_PMAP_LO];
   assign st_len  = i_stat_fifo_dout[STAT_LEN_HI:STAT_LEN_LO];
   assign st_bad  = st_err || (st_pmap == 4'd0) ||
                    (st_len < LEN_W'(MIN_LEN)) || (st_len > LEN_W'(MAX_LEN));

   // Bad frames are taken regardless of bp so they cannot block the queue.
   assign stat_take    = (state == ST_IDLE) && !i_stat_fifo_empty && (st_bad || !i_cell_bp);
   assign beat_cnt_inc = beat_cnt + 2'd1;

   always_comb begin
      ptr_word = '0;
      ptr_word[PTR_PMAP_HI:PTR_PMAP_LO] = pmap_q;
      ptr_word[PTR_CNT_HI:PTR_CNT_LO]   = cell_cnt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      pad_vld   = 1'b0;
      clr       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (stat_take) state_nxt = st_bad ? ST_DROP : ST_LOAD;
         end
         ST_LOAD: begin
            clr       = 1'b1;
            state_nxt = ST_PACK;
         end
         ST_PACK: begin
            if (!i_data_fifo_empty) begin
               pop = 1'b1;
               // Last byte closes the final data beat this cycle; its count is beat_cnt_inc.
               if (rem == LEN_W'(1)) state_nxt = (beat_cnt_inc != 2'd0) ? ST_PAD : ST_PTR;
            end
         end
         ST_PAD: begin
            pad_vld = 1'b1;
            if (beat_cnt_inc == 2'd0) state_nxt = ST_PTR;
         end
         ST_PTR: begin
            state_nxt = ST_IDLE;
         end
         ST_DROP: begin
            if (rem == '0) state_nxt = ST_IDLE;
            else if (!i_data_fifo_empty) pop = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         len_q       <= '0;
         rem         <= '0;
         pmap_q      <= '0;
         cell_cnt    <= '0;
         beat_cnt    <= '0;
         stat_rd_q   <= 1'b0;
         ptr_wr_q    <= 1'b0;
         ptr_dat_q   <= '0;
         o_frame_cnt <= '0;
         o_drop_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         stat_rd_q <= stat_take;
         ptr_wr_q  <= 1'b0;
         if (stat_take) begin
            len_q  <= st_len;
            rem    <= st_len;
            pmap_q <= st_pmap;
         end
         if (pop) rem <= rem - 1'b1;
         if (state == ST_LOAD) begin
            cell_cnt <= cells_for_len(len_q);
            beat_cnt <= '0;
         end else if (beat_done || pad_vld) begin
            beat_cnt <= beat_cnt_inc;
         end
         // The final beat is written in the PTR cycle at the latest, so the pointer lands after it.
         if (state == ST_PTR) begin
            ptr_wr_q    <= 1'b1;
            ptr_dat_q   <= ptr_word;
            o_frame_cnt <= o_frame_cnt + 16'd1;
         end
         if (state == ST_DROP && rem == '0) o_drop_cnt <= o_drop_cnt + 16'd1;
      end
   end

   assign i_stat_fifo_rd      = stat_rd_q;
   assign i_data_fifo_rd      = pop;
   assign o_cell_ptr_fifo_wr  = ptr_wr_q;
   assign o_cell_ptr_fifo_din = ptr_dat_q;

   cell_beat_packer u_packer (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .byte_vld  (pop && (state == ST_PACK)),
      .byte_dat  (i_data_fifo_dout),
      .byte_last (rem == LEN_W'(1)),
      .pad_vld   (pad_vld),
      .beat_done (beat_done),
      .beat_dat  (o_cell_data_fifo_din),
      .beat_wr   (o_cell_data_fifo_wr)
   );

endmodule
